// File: rtl/lfsr_pkg.sv
// Shared constants, FSM state type and the LFSR step function for the
// word scheduler and its LFSR core.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  localparam int TAP_A = 16;
  localparam int TAP_B = 15;
  localparam int TAP_C = 13;
  localparam int TAP_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Fibonacci step: feedback enters at stage 1, stage 16 is the output.
  function automatic logic [LFSR_W:1] lfsr_next(input logic [LFSR_W:1] s);
    logic fb;
    fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
    return {s[LFSR_W-1:1], fb};
  endfunction

endpackage

// File: rtl/lfsr16_core.sv
// 16-bit Fibonacci LFSR that advances only on request; a load takes
// precedence over a step.
module lfsr16_core
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W:1] SEED = 16'h0001
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              step,
  input  logic              load,
  input  logic [LFSR_W:1]   load_val,
  output logic [LFSR_W:1]   state,
  output logic              out
);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= SEED;
    end else if (load) begin
      state <= load_val;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

  assign out = state[LFSR_W];

endmodule

// File: rtl/lfsr_word_sched.sv
// Round-robin scheduler that builds WORD_W-bit random words from a shared
// LFSR for two requesters and returns each word tagged with its requester.
module lfsr_word_sched
  import lfsr_pkg::*;
#(
  parameter int              WORD_W = 8,
  parameter logic [LFSR_W-1:0] SEED = 16'h0001
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [1:0]        req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WORD_W-1:0] rsp_word
);

  localparam int CNT_W = $clog2(WORD_W + 1);

  state_t              state;
  state_t              state_next;
  logic [1:0]          pending;
  logic                last;
  logic                winner;
  logic                grant_en;
  logic [CNT_W-1:0]    cnt;
  logic                last_step;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   shreg_shift;
  logic                lfsr_out;
  logic [LFSR_W:1]     lfsr_state;
  logic [LFSR_W:1]     load_val;

  assign winner      = (pending == 2'b11) ? ~last : pending[1];
  assign last_step   = (cnt == CNT_W'(WORD_W - 1));
  assign shreg_shift = WORD_W'({shreg, lfsr_out});
  assign load_val    = (seed_val == '0) ? SEED : seed_val;
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == DONE);

  lfsr16_core #(
    .SEED (SEED)
  ) u_core (
    .clock    (clock),
    .clear    (clear),
    .step     (state == SHIFT),
    .load     ((state == IDLE) && seed_load),
    .load_val (load_val),
    .state    (lfsr_state),
    .out      (lfsr_out)
  );

  // A zero seed is always substituted, so the register can never lock up.
  assert property (@(posedge clock) disable iff (!clear) lfsr_state != '0);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Seed loading in IDLE pre-empts arbitration for that cycle.
  always_comb begin
    state_next = state;
    gnt        = '0;
    grant_en   = 1'b0;
    case (state)
      IDLE: begin
        if (!seed_load && (pending != 2'b00)) begin
          grant_en    = 1'b1;
          gnt[winner] = 1'b1;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A new request wins over the clear caused by its own grant.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      pending <= 2'b00;
      last    <= 1'b1;
    end else begin
      pending <= (pending & ~gnt) | req;
      if (grant_en) begin
        last <= winner;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (grant_en) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (state == SHIFT) begin
      cnt   <= cnt + CNT_W'(1);
      shreg <= shreg_shift;
    end
  end

  // Response registers capture the finished word so it survives the next grant.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rsp_word <= '0;
      rsp_id   <= 1'b0;
    end else if ((state == SHIFT) && last_step) begin
      rsp_word <= shreg_shift;
      rsp_id   <= last;
    end
  end

endmodule

// File: tb/tb_lfsr_word_sched.sv
// Self-checking bench: a transaction/timing model predicts grants, busy and
// responses cycle by cycle; two extra instances cover the width corners.
module tb_lfsr_word_sched;

  localparam int          W    = 8;
  localparam logic [15:0] SEED = 16'h0001;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          clear;
  logic [1:0]    req;
  logic          seed_load;
  logic [15:0]   seed_val;
  logic [1:0]    gnt;
  logic          busy, rsp_valid, rsp_id;
  logic [W-1:0]  rsp_word;

  logic [1:0]    req_c;
  logic [1:0]    gnt16, gnt1;
  logic          busy16, busy1, rsp_valid16, rsp_valid1, rsp_id16, rsp_id1;
  logic [15:0]   rsp_word16;
  logic [0:0]    rsp_word1;

  lfsr_word_sched #(.WORD_W(W), .SEED(SEED)) dut (
    .clock(clock), .clear(clear), .req(req), .seed_load(seed_load),
    .seed_val(seed_val), .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_word(rsp_word)
  );

  lfsr_word_sched #(.WORD_W(16), .SEED(SEED)) dut16 (
    .clock(clock), .clear(clear), .req(req_c), .seed_load(1'b0),
    .seed_val(16'h0000), .gnt(gnt16), .busy(busy16), .rsp_valid(rsp_valid16),
    .rsp_id(rsp_id16), .rsp_word(rsp_word16)
  );

  lfsr_word_sched #(.WORD_W(1), .SEED(SEED)) dut1 (
    .clock(clock), .clear(clear), .req(req_c), .seed_load(1'b0),
    .seed_val(16'h0000), .gnt(gnt1), .busy(busy1), .rsp_valid(rsp_valid1),
    .rsp_id(rsp_id1), .rsp_word(rsp_word1)
  );

  int checks = 0;
  int errors = 0;

  int          cyc;
  int          idle_at;
  int          rsp_at;
  logic [15:0] m_lfsr;
  logic [1:0]  m_pend;
  int          m_last;
  logic [W-1:0] m_next_word, m_held_word;
  int          m_next_id, m_held_id;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bit stream view of the generator: emit the top stage, then shift in the tap parity.
  function automatic logic [15:0] seqStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], fb};
  endfunction

  task automatic modelReset();
    m_lfsr      = SEED;
    m_pend      = 2'b00;
    m_last      = 1;
    idle_at     = cyc;
    rsp_at      = -1;
    m_held_word = '0;
    m_held_id   = 0;
    m_next_word = '0;
    m_next_id   = 0;
  endtask

  // One clock cycle: drive inputs, predict, compare at negedge, step past the edge.
  task automatic applyStimulus(input logic [1:0] r, input logic sl, input logic [15:0] sv);
    logic [1:0]   exp_gnt;
    logic         idle;
    logic [W-1:0] w;
    int           win;
    req       = r;
    seed_load = sl;
    seed_val  = sv;
    exp_gnt   = 2'b00;
    idle      = (cyc >= idle_at);
    if (idle) begin
      if (sl) begin
        m_lfsr = (sv == 16'h0000) ? SEED : sv;
      end else if (m_pend != 2'b00) begin
        win          = (m_pend == 2'b11) ? (1 - m_last) : (m_pend[1] ? 1 : 0);
        exp_gnt[win] = 1'b1;
        m_last       = win;
        m_pend[win]  = 1'b0;
        w            = '0;
        for (int i = 0; i < W; i++) begin
          w      = {w[W-2:0], m_lfsr[15]};
          m_lfsr = seqStep(m_lfsr);
        end
        m_next_word = w;
        m_next_id   = win;
        rsp_at      = cyc + W + 1;
        idle_at     = cyc + W + 2;
      end
    end
    if (cyc == rsp_at) begin
      m_held_word = m_next_word;
      m_held_id   = m_next_id;
    end
    m_pend = m_pend | r;
    @(negedge clock);
    checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
    checkOutput("busy", 32'(busy), 32'(!idle));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(cyc == rsp_at));
    checkOutput("rsp_id", 32'(rsp_id), 32'(m_held_id));
    checkOutput("rsp_word", 32'(rsp_word), 32'(m_held_word));
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 1'b0, 16'h0000);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must drop without waiting for an edge.
  task automatic doReset();
    clear     = 1'b0;
    req       = 2'b00;
    seed_load = 1'b0;
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    cyc++;
    modelReset();
  endtask

  int g16, r16, g1, r1;
  logic [15:0] w16;
  logic        w1;

  initial begin
    clear     = 1'b0;
    req       = 2'b00;
    req_c     = 2'b00;
    seed_load = 1'b0;
    seed_val  = 16'h0000;
    cyc       = 0;
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_word", 32'(rsp_word), 32'd0);
    checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    modelReset();

    $display("[TB] seed-1 sequence");
    applyStimulus(2'b01, 1'b0, 16'h0000);
    idleCycles(12);
    checkOutput("seed1_word0", 32'(rsp_word), 32'h00);
    applyStimulus(2'b01, 1'b0, 16'h0000);
    idleCycles(12);
    checkOutput("seed1_word1", 32'(rsp_word), 32'h01);

    $display("[TB] round robin");
    applyStimulus(2'b11, 1'b0, 16'h0000);
    idleCycles(22);
    applyStimulus(2'b11, 1'b0, 16'h0000);
    applyStimulus(2'b00, 1'b0, 16'h0000);
    applyStimulus(2'b10, 1'b0, 16'h0000);
    idleCycles(30);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b10, 1'b0, 16'h0000);
      idleCycles(11);
    end

    $display("[TB] seed handling");
    applyStimulus(2'b00, 1'b1, 16'h0000);
    applyStimulus(2'b01, 1'b0, 16'h0000);
    idleCycles(12);
    checkOutput("reseed_word0", 32'(rsp_word), 32'h00);
    applyStimulus(2'b01, 1'b0, 16'h0000);
    idleCycles(3);
    applyStimulus(2'b00, 1'b1, 16'hBEEF);
    idleCycles(10);

    $display("[TB] simultaneous events");
    applyStimulus(2'b01, 1'b0, 16'h0000);
    applyStimulus(2'b00, 1'b1, 16'h1234);
    idleCycles(12);
    applyStimulus(2'b10, 1'b0, 16'h0000);
    applyStimulus(2'b10, 1'b0, 16'h0000);
    idleCycles(24);

    $display("[TB] reset mid-operation");
    applyStimulus(2'b01, 1'b0, 16'h0000);
    idleCycles(4);
    doReset();
    idleCycles(12);
    applyStimulus(2'b01, 1'b0, 16'h0000);
    idleCycles(12);
    checkOutput("post_reset_word0", 32'(rsp_word), 32'h00);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      logic [1:0]  r;
      logic        sl;
      logic [15:0] sv;
      r  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      sl = ($urandom_range(0, 15) == 0);
      sv = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom_range(0, 199) == 0) doReset();
      else applyStimulus(r, sl, sv);
    end

    $display("[TB] width corners");
    req_c = 2'b01;
    @(posedge clock);
    #1;
    req_c = 2'b00;
    g16 = -1; r16 = -1; g1 = -1; r1 = -1; w16 = '0; w1 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (gnt16 != 2'b00 && g16 < 0) g16 = k;
      if (rsp_valid16 && r16 < 0) begin r16 = k; w16 = rsp_word16; end
      if (gnt1 != 2'b00 && g1 < 0) g1 = k;
      if (rsp_valid1 && r1 < 0) begin r1 = k; w1 = rsp_word1[0]; end
    end
    checkOutput("w16_seen", 32'(r16 >= 0 && g16 >= 0), 32'd1);
    checkOutput("w16_latency", 32'(r16 - g16), 32'd17);
    checkOutput("w16_word", 32'(w16), 32'h0001);
    checkOutput("w1_seen", 32'(r1 >= 0 && g1 >= 0), 32'd1);
    checkOutput("w1_latency", 32'(r1 - g1), 32'd2);
    checkOutput("w1_word", 32'(w1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
